// File: rtl/addsub_accumulator.sv
// addsub_accumulator
// Frame-based two's-complement add/subtract accumulator. Each accepted sample
// is added to or subtracted from the running value. After LEN samples the
// block holds the frame result (value, last carry, sticky signed overflow)
// until the consumer takes it. It then clears itself and starts the next frame.
module addsub_accumulator #(
    parameter int N   = 4,
    parameter int LEN = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] acc_data,
    output logic         acc_carry,
    output logic         acc_ovf
);

    // The sample counter is at least one bit wide, so LEN = 1 still elaborates.
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;

    logic          accept;
    logic          release_hs;
    logic          last_sample;
    logic [N-1:0]  operand;
    logic [N:0]    sum;
    logic [N-1:0]  low_sum;
    logic          ovf_now;

    // The handshake flags depend only on the state register. This keeps
    // out_ready from reaching in_ready through combinational logic.
    assign in_ready    = (state_q == ACCUM);
    assign out_valid   = (state_q == HOLD);
    assign accept      = in_valid && in_ready;
    assign release_hs  = out_valid && out_ready;
    assign last_sample = (cnt_q == CW'(LEN - 1));

    // Subtraction is done as acc + ~in_data + 1, so a carry-out of 1 means no borrow.
    assign operand = in_data ^ {N{in_sub}};
    assign sum     = {1'b0, acc_data} + {1'b0, operand} + {{N{1'b0}}, in_sub};

    // Signed overflow is the carry into the MSB XOR the carry out of the MSB.
    // The carry into the MSB comes from the sum of the lower N-1 bits.
    assign low_sum = {1'b0, acc_data[N-2:0]} + {1'b0, operand[N-2:0]}
                   + {{(N-1){1'b0}}, in_sub};
    assign ovf_now = low_sum[N-1] ^ sum[N];

    // State register; reset abandons any partial or pending frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clr wins over everything, the LEN-th accept enters HOLD,
    // and the consumer handshake leaves it.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept && last_sample) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // Datapath registers. They are cleared on clr or on the result handshake
    // and update only on an accepted sample. The sample counter wraps to 0 on
    // the frame's last accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data  <= '0;
            acc_carry <= 1'b0;
            acc_ovf   <= 1'b0;
            cnt_q     <= '0;
        end else if (clr || release_hs) begin
            acc_data  <= '0;
            acc_carry <= 1'b0;
            acc_ovf   <= 1'b0;
            cnt_q     <= '0;
        end else if (accept) begin
            acc_data  <= sum[N-1:0];
            acc_carry <= sum[N];
            acc_ovf   <= acc_ovf | ovf_now;
            cnt_q     <= last_sample ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_addsub_accumulator.sv
// tb_addsub_accumulator
// Self-checking bench for addsub_accumulator with N=4, LEN=4. It runs a
// table of directed vectors, then hand-written clr and reset sequences, then
// random traffic checked against an arithmetic reference model.
module tb_addsub_accumulator;

    localparam int N   = 4;
    localparam int LEN = 4;

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] acc_data;
    logic         acc_carry;
    logic         acc_ovf;

    int errors = 0;
    int checks = 0;

    // Reference model state: the frame value as an unsigned int, the flags,
    // the number of samples taken so far and whether a result is pending.
    int m_acc;
    int m_carry;
    int m_ovf;
    int m_cnt;
    int m_hold;

    typedef struct {
        logic       clr;
        logic       iv;
        logic [3:0] d;
        logic       sub;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_acc;
        logic       e_c;
        logic       e_o;
    } vec_t;

    vec_t vecs[$];

    addsub_accumulator #(.N(N), .LEN(LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_data  (acc_data),
        .acc_carry (acc_carry),
        .acc_ovf   (acc_ovf)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic c, input logic iv, input logic [3:0] d,
                                input logic sub, input logic ordy, input logic e_ir,
                                input logic e_ov, input logic [3:0] e_acc,
                                input logic e_c, input logic e_o);
        vec_t v;
        v.clr = c; v.iv = iv; v.d = d; v.sub = sub; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_acc = e_acc; v.e_c = e_c; v.e_o = e_o;
        return v;
    endfunction

    // Drive one cycle of inputs, then let one rising edge pass and settle 1 ns after it.
    task automatic applyStimulus(input logic c, input logic iv, input logic [3:0] d,
                                 input logic sub, input logic ordy);
        clr       = c;
        in_valid  = iv;
        in_data   = d;
        in_sub    = sub;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic e_ir, input logic e_ov,
                               input logic [3:0] e_acc, input logic e_c, input logic e_o);
        checks++;
        if (in_ready !== e_ir || out_valid !== e_ov || acc_data !== e_acc ||
            acc_carry !== e_c || acc_ovf !== e_o) begin
            errors++;
            $display("[TB] FAIL %s: got ir=%b ov=%b acc=%b c=%b o=%b, expected ir=%b ov=%b acc=%b c=%b o=%b",
                     name, in_ready, out_valid, acc_data, acc_carry, acc_ovf,
                     e_ir, e_ov, e_acc, e_c, e_o);
        end
    endtask

    task automatic modelClear();
        m_acc = 0; m_carry = 0; m_ovf = 0; m_cnt = 0; m_hold = 0;
    endtask

    // One clock of the frame rules, done in plain signed/unsigned arithmetic.
    task automatic modelStep(input logic c, input logic iv, input int d,
                             input logic sub, input logic ordy);
        int sa;
        int sd;
        int rs;
        if (c) begin
            modelClear();
        end else if (m_hold != 0) begin
            if (ordy) modelClear();
        end else if (iv) begin
            sa = (m_acc >= 8) ? m_acc - 16 : m_acc;
            sd = (d >= 8) ? d - 16 : d;
            if (sub) begin
                m_carry = (m_acc >= d) ? 1 : 0;
                rs = sa - sd;
                m_acc = (m_acc - d + 16) % 16;
            end else begin
                m_carry = (m_acc + d >= 16) ? 1 : 0;
                rs = sa + sd;
                m_acc = (m_acc + d) % 16;
            end
            if (rs > 7 || rs < -8) m_ovf = 1;
            m_cnt++;
            if (m_cnt == LEN) begin
                m_cnt = 0;
                m_hold = 1;
            end
        end
    endtask

    // Main sequence: reset, directed table, clr/reset corner cases, random run.
    initial begin
        logic       rc;
        logic       riv;
        logic [3:0] rd;
        logic       rsub;
        logic       rordy;

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        in_sub = 1'b0; out_ready = 1'b0;
        #12;
        checkOutput("reset", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Add frame 1,2,3,1 with an idle cycle in between, then backpressure and release
        vecs.push_back(mk(0,1,4'd1,0,0, 1,0,4'h1,0,0));
        vecs.push_back(mk(0,1,4'd2,0,0, 1,0,4'h3,0,0));
        vecs.push_back(mk(0,0,4'd9,1,0, 1,0,4'h3,0,0));
        vecs.push_back(mk(0,1,4'd3,0,0, 1,0,4'h6,0,0));
        vecs.push_back(mk(0,1,4'd1,0,0, 0,1,4'h7,0,0));
        vecs.push_back(mk(0,1,4'd5,0,0, 0,1,4'h7,0,0));
        vecs.push_back(mk(0,1,4'd5,1,0, 0,1,4'h7,0,0));
        vecs.push_back(mk(0,1,4'd5,0,0, 0,1,4'h7,0,0));
        vecs.push_back(mk(0,1,4'd5,0,1, 1,0,4'h0,0,0));
        // Sticky overflow: 7,1,0,0
        vecs.push_back(mk(0,1,4'd7,0,0, 1,0,4'h7,0,0));
        vecs.push_back(mk(0,1,4'd1,0,0, 1,0,4'h8,0,1));
        vecs.push_back(mk(0,1,4'd0,0,0, 1,0,4'h8,0,1));
        vecs.push_back(mk(0,1,4'd0,0,0, 0,1,4'h8,0,1));
        vecs.push_back(mk(0,0,4'd0,0,1, 1,0,4'h0,0,0));
        // Subtract 3 four times from zero
        vecs.push_back(mk(0,1,4'd3,1,0, 1,0,4'hD,0,0));
        vecs.push_back(mk(0,1,4'd3,1,0, 1,0,4'hA,1,0));
        vecs.push_back(mk(0,1,4'd3,1,0, 1,0,4'h7,1,1));
        vecs.push_back(mk(0,1,4'd3,1,0, 0,1,4'h4,1,1));
        vecs.push_back(mk(0,0,4'd0,0,1, 1,0,4'h0,0,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].clr, vecs[i].iv, vecs[i].d, vecs[i].sub, vecs[i].ordy);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov,
                        vecs[i].e_acc, vecs[i].e_c, vecs[i].e_o);
        end

        // Clear after two accepts drops the offered sample and restarts the count
        applyStimulus(0,1,4'd2,0,0);
        applyStimulus(0,1,4'd3,0,0);
        checkOutput("pre_clr", 1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
        applyStimulus(1,1,4'd7,0,0);
        checkOutput("clr_drop", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(0,1,4'd1,0,0);
        applyStimulus(0,1,4'd1,0,0);
        applyStimulus(0,1,4'd1,0,0);
        checkOutput("clr_cnt3", 1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
        applyStimulus(0,1,4'd1,0,0);
        checkOutput("clr_cnt4", 1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
        // clr in HOLD without out_ready still releases and clears
        applyStimulus(1,1,4'd6,0,0);
        checkOutput("clr_hold", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame, observed before any clock edge
        applyStimulus(0,1,4'd7,0,0);
        applyStimulus(0,1,4'd1,0,0);
        checkOutput("pre_rst", 1'b1, 1'b0, 4'h8, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_rst", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        applyStimulus(0,1,4'd2,0,0);
        checkOutput("rst_first_accept", 1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
        applyStimulus(0,1,4'd2,0,0);
        applyStimulus(0,1,4'd2,0,0);
        checkOutput("rst_cnt3", 1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
        applyStimulus(0,1,4'd2,0,0);
        checkOutput("rst_cnt4", 1'b0, 1'b1, 4'h8, 1'b0, 1'b1);
        // Reset while holding a result discards it
        #2 rst_n = 1'b0;
        #1 checkOutput("rst_hold", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;

        // Random traffic against the reference model
        modelClear();
        for (int k = 0; k < 400; k++) begin
            rc    = ($urandom_range(0, 19) == 0);
            riv   = ($urandom_range(0, 3) != 0);
            rd    = 4'($urandom_range(0, 15));
            rsub  = 1'($urandom_range(0, 1));
            rordy = 1'($urandom_range(0, 1));
            applyStimulus(rc, riv, rd, rsub, rordy);
            modelStep(rc, riv, int'(rd), rsub, rordy);
            checkOutput($sformatf("rand%0d", k), (m_hold == 0), (m_hold != 0),
                        4'(m_acc), 1'(m_carry), 1'(m_ovf));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_accumulator.md
ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

Interface
REQ-001 SHALL have parameter N, default 4: operand/accumulator width in bits, N >= 2.
REQ-002 SHALL have parameter LEN, default 4: samples per frame, LEN >= 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous frame abort and clear.
REQ-006 SHALL have port in_valid  input  1  in_data/in_sub valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port in_data  input  N  two's-complement operand.
REQ-009 SHALL have port in_sub  input  1  per-sample operation: 0 = add, 1 = subtract.
REQ-010 SHALL have port out_valid  output  1  frame result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port acc_data  output  N  accumulator value.
REQ-013 SHALL have port acc_carry  output  1  carry-out of the last accepted operation.
REQ-014 SHALL have port acc_ovf  output  1  sticky signed overflow for the current frame.

Function
REQ-015 SHALL implement a two-state FSM: ACCUM and HOLD.
REQ-016 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 A sample is accepted when in_valid && in_ready; non-accepted cycles SHALL leave all state unchanged.
REQ-018 On accept, acc SHALL be updated to acc + (in_data XOR {N{in_sub}}) + in_sub, truncated to N bits (wrap-around), one-cycle latency.
REQ-019 On accept, acc_carry SHALL take bit N of that (N+1)-bit sum; for subtraction, 1 means no borrow.
REQ-020 On accept, acc_ovf SHALL become acc_ovf OR V, where V = carry into the MSB XOR carry out of the MSB.
REQ-021 A frame sample counter (0..LEN-1, width clog2(LEN) with minimum 1) SHALL increment on each accept; on the LEN-th accept it SHALL reset to 0 and the FSM SHALL go to HOLD on the same edge.
REQ-022 In HOLD, acc_data, acc_carry, and acc_ovf SHALL stay stable until out_valid && out_ready.
REQ-023 On the HOLD handshake, the block SHALL clear acc, acc_carry, acc_ovf, and the counter to 0 and return to ACCUM; in_ready SHALL be 1 in the following cycle, with no combinational path from out_ready to in_ready.
REQ-024 clr=1 SHALL, on the next edge and in any state, clear acc, carry, ovf, and the counter and enter ACCUM; any sample offered that cycle SHALL be dropped.
REQ-025 clr SHALL take priority over accept and over the HOLD handshake.
REQ-026 acc_data, acc_carry, and acc_ovf SHALL be driven directly from registers.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force state=ACCUM, counter=0, acc_data=0, acc_carry=0, and acc_ovf=0, giving in_ready=1 and out_valid=0.
REQ-028 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result.
REQ-029 After rst_n rises, the first accept SHALL be possible at the first clk edge.

Verification (N=4, LEN=4)
REQ-030 Reset: assert rst_n=0 between edges -> outputs 0 immediately; in_ready=1, out_valid=0.
REQ-031 Add frame: add 1,2,3,1 on consecutive cycles -> after 4th edge out_valid=1, acc_data=0111, carry=0, ovf=0.
REQ-032 Sticky overflow: add 7,1,0,0 -> after 2nd accept acc=1000 and ovf=1; frame result acc=1000, ovf=1, carry=0.
REQ-033 Subtract frame from 0: sub 3 four times -> acc values 1101(c0), 1010(c1), 0111(c1, V=1), 0100(c1); result 0100, carry=1, ovf=1.
REQ-034 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, nothing accepted; then out_ready=1 -> next cycle acc=0, ovf=0, in_ready=1.
REQ-035 Abort and reset: after 2 accepts assert clr -> next edge acc=0, counter=0, and the frame needs 4 new samples; repeat with rst_n pulsed low mid-frame -> same cleared state without a clock edge.
